// File: rtl/decoder_pkg.sv
// cpuConfig: shared widths and encodings for the picoMIPS opcode and ALU select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpuConfig;

  localparam int A_SIZE = 2;
  localparam int O_SIZE = 3;

  typedef enum logic [O_SIZE-1:0] {
    MOV  = 3'd0,
    ADD  = 3'd1,
    ADDI = 3'd2,
    SUB  = 3'd3,
    SUBI = 3'd4,
    MUL  = 3'd5,
    MULI = 3'd6,
    LDS  = 3'd7
  } opCode_t;

  typedef enum logic [A_SIZE-1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MUL   = 2'd2,
    ALU_PASSB = 2'd3
  } aluFunc_t;

endpackage

// File: rtl/decoder_if.sv
// decoder_if: opcode/switch inputs and decoded control outputs of the picoMIPS decoder.
// Latency: n/a (wires only).
// Backpressure: none; the decoder stalls the PC itself through pcInc.
//   master: drives opCode, demoSwitch; reads aluFunc, aluImmediate, immSwitches, pcInc
//   slave : the decoder side, opposite directions
interface decoder_if;
  import cpuConfig::*;

  opCode_t  opCode;
  logic     demoSwitch;
  aluFunc_t aluFunc;
  logic     aluImmediate;
  logic     immSwitches;
  logic     pcInc;

  modport master (
    output opCode, demoSwitch,
    input  aluFunc, aluImmediate, immSwitches, pcInc
  );

  modport slave (
    input  opCode, demoSwitch,
    output aluFunc, aluImmediate, immSwitches, pcInc
  );

endinterface

// File: rtl/decoder_sync2.sv
// sync2: two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
//   clk in, nReset in (async active-low, clears both flops), d in (async), q out
module sync2 (
  input  logic clk,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/decoder.sv
// decoder: picoMIPS opcode -> ALU select, B-operand source, immediate source, PC enable.
// Latency: outputs combinational from opCode; demo switch seen 2 clks after it moves.
// Backpressure: LDS holds pcInc low until a fresh synchronized switch press.
//   clk in, nReset in (async active-low)
//   bus (decoder_if.slave): opCode, demoSwitch in; aluFunc, aluImmediate, immSwitches, pcInc out
module decoder
  import cpuConfig::*;
(
  input  logic       clk,
  input  logic       nReset,
  decoder_if.slave   bus
);

  logic     w_demoSync;
  logic     w_ldsGo;
  logic     r_armed;
  aluFunc_t w_aluFunc;
  logic     w_aluImmediate;
  logic     w_immSwitches;
  logic     w_pcInc;

  sync2 u_sync2 (
    .clk    (clk),
    .nReset (nReset),
    .d      (bus.demoSwitch),
    .q      (w_demoSync)
  );

  // Only the synchronized switch feeds the outputs, so a bouncing raw input
  // can never glitch pcInc.
  assign w_ldsGo = w_demoSync & r_armed;

  // armed re-arms whenever the switch is seen released; it is consumed by the
  // LDS that completes, so holding the switch down cannot run several LDSs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_armed <= 1'b1;
    end else if (!w_demoSync) begin
      r_armed <= 1'b1;
    end else if (bus.opCode == LDS && w_ldsGo) begin
      r_armed <= 1'b0;
    end
  end

  always_comb begin
    // Defaults are the MOV decode, which also covers unknown opcodes.
    w_aluFunc      = ALU_PASSB;
    w_aluImmediate = 1'b0;
    w_immSwitches  = 1'b0;
    w_pcInc        = 1'b1;
    case (bus.opCode)
      MOV:  w_aluFunc = ALU_PASSB;
      ADD:  w_aluFunc = ALU_ADD;
      ADDI: begin
        w_aluFunc      = ALU_ADD;
        w_aluImmediate = 1'b1;
      end
      SUB:  w_aluFunc = ALU_SUB;
      SUBI: begin
        w_aluFunc      = ALU_SUB;
        w_aluImmediate = 1'b1;
      end
      MUL:  w_aluFunc = ALU_MUL;
      MULI: begin
        w_aluFunc      = ALU_MUL;
        w_aluImmediate = 1'b1;
      end
      LDS: begin
        w_aluFunc      = ALU_PASSB;
        w_aluImmediate = 1'b1;
        w_immSwitches  = 1'b1;
        w_pcInc        = w_ldsGo;
      end
      default: begin
        w_aluFunc = ALU_PASSB;
        w_pcInc   = 1'b1;
      end
    endcase
  end

  assign bus.aluFunc      = w_aluFunc;
  assign bus.aluImmediate = w_aluImmediate;
  assign bus.immSwitches  = w_immSwitches;
  assign bus.pcInc        = w_pcInc;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed self-checking bench for the picoMIPS decoder.
// Observed vector is {aluFunc[1:0], aluImmediate, immSwitches, pcInc}.
// Inputs change and outputs are sampled 1ns after the falling clock edge.
module tb_decoder;
  import cpuConfig::*;

  logic clk;
  logic nReset;
  int   checks;
  int   errors;
  logic [4:0] obs;

  decoder_if bus ();

  decoder dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors: {aluFunc, aluImm, immSw, pcInc}
  localparam logic [4:0] E_MOV      = 5'b11_0_0_1;
  localparam logic [4:0] E_ADD      = 5'b00_0_0_1;
  localparam logic [4:0] E_ADDI     = 5'b00_1_0_1;
  localparam logic [4:0] E_SUB      = 5'b01_0_0_1;
  localparam logic [4:0] E_SUBI     = 5'b01_1_0_1;
  localparam logic [4:0] E_MUL      = 5'b10_0_0_1;
  localparam logic [4:0] E_MULI     = 5'b10_1_0_1;
  localparam logic [4:0] E_LDS_STALL = 5'b11_1_1_0;
  localparam logic [4:0] E_LDS_GO    = 5'b11_1_1_1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    bus.opCode = ADD;
    bus.demoSwitch = 1'b0;
    step();
    step();
    obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
    checks++;
    if (obs !== E_ADD) begin
      errors++;
      $display("FAIL reset_add got %b want %b", obs, E_ADD);
    end
    bus.opCode = LDS;
    #1;
    obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
    checks++;
    if (obs !== E_LDS_STALL) begin
      errors++;
      $display("FAIL reset_lds got %b want %b", obs, E_LDS_STALL);
    end
    bus.opCode = ADD;
    step();
    nReset = 1'b1;
    step();
    obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
    checks++;
    if (obs !== E_ADD) begin
      errors++;
      $display("FAIL post_reset_add got %b want %b", obs, E_ADD);
    end
  endtask

  task automatic test_lds_stall();
    bus.opCode = LDS;
    bus.demoSwitch = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
      checks++;
      if (obs !== E_LDS_STALL) begin
        errors++;
        $display("FAIL lds_stall cycle %0d got %b want %b", i, obs, E_LDS_STALL);
      end
    end
  endtask

  // Press with LDS held: one-cycle go pulse two clocks after the press.
  task automatic press_and_expect_pulse(input string name);
    logic [4:0] exp_seq [4];
    exp_seq[0] = E_LDS_STALL;
    exp_seq[1] = E_LDS_GO;
    exp_seq[2] = E_LDS_STALL;
    exp_seq[3] = E_LDS_STALL;
    bus.demoSwitch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL %s clk %0d got %b want %b", name, i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_lds_release();
    bus.opCode = LDS;
    press_and_expect_pulse("lds_press");
  endtask

  task automatic test_repress();
    bus.opCode = LDS;
    bus.demoSwitch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
      checks++;
      if (obs !== E_LDS_STALL) begin
        errors++;
        $display("FAIL release_stall clk %0d got %b want %b", i, obs, E_LDS_STALL);
      end
    end
    press_and_expect_pulse("lds_repress");
  endtask

  task automatic test_decode_table();
    opCode_t    ops  [6];
    logic [4:0] exps [6];
    ops[0] = MOV;  exps[0] = E_MOV;
    ops[1] = ADDI; exps[1] = E_ADDI;
    ops[2] = SUB;  exps[2] = E_SUB;
    ops[3] = SUBI; exps[3] = E_SUBI;
    ops[4] = MUL;  exps[4] = E_MUL;
    ops[5] = MULI; exps[5] = E_MULI;
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 2; s++) begin
        bus.opCode = ops[i];
        bus.demoSwitch = s[0];
        step();
        obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
        checks++;
        if (obs !== exps[i]) begin
          errors++;
          $display("FAIL decode op %0d sw %0d got %b want %b", i, s, obs, exps[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [4:0] exp_seq [3];
    exp_seq[0] = E_LDS_STALL;
    exp_seq[1] = E_LDS_GO;
    exp_seq[2] = E_LDS_STALL;
    bus.opCode = LDS;
    bus.demoSwitch = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.demoSwitch = 1'b1;
    for (int i = 0; i < 4; i++) step();
    obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
    checks++;
    if (obs !== E_LDS_STALL) begin
      errors++;
      $display("FAIL pre_reset_stall got %b want %b", obs, E_LDS_STALL);
    end
    nReset = 1'b0;
    #1;
    obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
    checks++;
    if (obs !== E_LDS_STALL) begin
      errors++;
      $display("FAIL in_reset_stall got %b want %b", obs, E_LDS_STALL);
    end
    step();
    step();
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {bus.aluFunc, bus.aluImmediate, bus.immSwitches, bus.pcInc};
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL post_reset_lds clk %0d got %b want %b", i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    bus.opCode = ADD;
    bus.demoSwitch = 1'b0;
    test_reset();
    test_lds_stall();
    test_lds_release();
    test_repress();
    test_decode_table();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
